// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit:
//   - mdu_op encodings (the decoder's ALUOP values when aluSel=1)
//   - default busy-cycle counts for multiply and divide
//   - control FSM state encoding
//   - down-counter width
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Wide enough for any realistic busy-cycle count.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_core.sv
// -----------------------------------------------------------------------------
// mdu_core
// MIPS-style multiply/divide unit holding the architectural HI/LO registers.
// A mult/multu/div/divu computes its 64-bit result when it is accepted, holds
// it in a pending register, and commits it to HI/LO after a fixed number of
// busy cycles. mthi/mtlo write HI/LO in a single cycle; mfhi/mflo read them
// combinationally.
//
// Ports:
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous active-high reset
//   mdu_en    in   1   E-stage instruction is an MDU instruction
//   mdu_op    in   3   operation (see mdu_pkg::mdu_op_e)
//   src_a     in   32  rs operand
//   src_b     in   32  rt operand
//   mdu_out   out  32  mfhi/mflo read data, zero otherwise
//   busy      out  1   multi-cycle operation in progress
//   md_stall  out  1   stall request for the hazard unit
//   hi_q      out  32  architectural HI
//   lo_q      out  32  architectural LO
// -----------------------------------------------------------------------------
module mdu_core
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdu_en,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] mdu_out,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    mdu_state_e        r_state;
    mdu_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [63:0]       r_pend;
    logic              r_pend_wr;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic              w_is_md;
    logic              w_is_mult;
    logic              w_sgn_op;
    logic              w_start;
    logic              w_done;

    logic signed [63:0] w_ma;
    logic signed [63:0] w_mb;
    logic signed [63:0] w_prod;

    logic [31:0]       w_dvd;
    logic [31:0]       w_dvs;
    logic [31:0]       w_q;
    logic [31:0]       w_r;
    logic [31:0]       w_q_fix;
    logic [31:0]       w_r_fix;

    logic [63:0]       w_res;
    logic              w_res_wr;

    // Two's-complement helpers for the sign-magnitude divider.
    function automatic logic [31:0] f_neg(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of a signed value; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [31:0] f_abs(input logic [31:0] x);
        return x[31] ? f_neg(x) : x;
    endfunction

    assign w_is_md   = (mdu_op <= OP_DIVU);
    assign w_is_mult = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign w_sgn_op  = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
    assign w_start   = mdu_en && w_is_md && (r_state == ST_IDLE);
    assign w_done    = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));

    // One 64x64 multiplier serves both mult and multu: operands are sign- or
    // zero-extended and the low 64 bits of the product are exact either way.
    always_comb begin
        w_ma   = w_sgn_op ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
        w_mb   = w_sgn_op ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
        w_prod = w_ma * w_mb;
    end

    // One unsigned divider serves both div and divu. Signed division runs on
    // magnitudes and re-applies signs afterwards, which also yields
    // 0x80000000 / -1 = 0x80000000 rem 0 without signed overflow.
    // The divisor is forced non-zero so the divider never sees 0; the result
    // is discarded in that case anyway.
    always_comb begin
        w_dvd   = w_sgn_op ? f_abs(src_a) : src_a;
        w_dvs   = w_sgn_op ? f_abs(src_b) : src_b;
        if (w_dvs == 32'd0) begin
            w_dvs = 32'd1;
        end
        w_q     = w_dvd / w_dvs;
        w_r     = w_dvd % w_dvs;
        w_q_fix = (w_sgn_op && (src_a[31] ^ src_b[31])) ? f_neg(w_q) : w_q;
        w_r_fix = (w_sgn_op && src_a[31]) ? f_neg(w_r) : w_r;
    end

    always_comb begin
        w_res    = 64'd0;
        w_res_wr = 1'b1;
        if (w_is_mult) begin
            w_res = w_prod;
        end else begin
            w_res    = {w_r_fix, w_q_fix};
            w_res_wr = (src_b != 32'd0);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_done)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (r_state == ST_RUN);
        md_stall = busy || (mdu_en && w_is_md);
        mdu_out  = 32'd0;
        if (mdu_en && (mdu_op == OP_MFHI)) begin
            mdu_out = r_hi;
        end else if (mdu_en && (mdu_op == OP_MFLO)) begin
            mdu_out = r_lo;
        end
    end

    // Counter, pending result and HI/LO. Anything presented while busy is
    // ignored because both the start and the mthi/mtlo paths require IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_pend    <= 64'd0;
            r_pend_wr <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            if (w_start) begin
                r_pend    <= w_res;
                r_pend_wr <= w_res_wr;
                r_cnt     <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_done) begin
                if (r_pend_wr) begin
                    r_hi <= r_pend[63:32];
                    r_lo <= r_pend[31:0];
                end
            end else if (mdu_en && (r_state == ST_IDLE)) begin
                if (mdu_op == OP_MTHI) r_hi <= src_a;
                if (mdu_op == OP_MTLO) r_lo <= src_a;
            end
        end
    end

    assign hi_q = r_hi;
    assign lo_q = r_lo;

endmodule

// File: tb/tb_mdu_core.sv
// -----------------------------------------------------------------------------
// tb_mdu_core
// Scoreboard bench for mdu_core. The driver pushes expected HI/LO/busy-length
// entries for every multi-cycle op and expected read data for every mfhi/mflo;
// a monitor on the falling edge pops and compares when the DUT completes an
// operation or presents read data.
// -----------------------------------------------------------------------------
module tb_mdu_core;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdu_en;
    logic [2:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] mdu_out;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    exp_t        q_done[$];
    logic [31:0] q_read[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    bit          abort_flag = 1'b0;

    mdu_core dut (
        .clk      (clk),
        .reset    (reset),
        .mdu_en   (mdu_en),
        .mdu_op   (mdu_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mdu_out  (mdu_out),
        .busy     (busy),
        .md_stall (md_stall),
        .hi_q     (hi_q),
        .lo_q     (lo_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: MIPS HI/LO semantics in plain 64-bit arithmetic.
    function automatic exp_t model_md(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        exp_t        e;
        longint      p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      rm;
        logic [63:0] r;
        e.hi = m_hi;
        e.lo = m_lo;
        e.n  = (op <= 3'd1) ? MULT_N : DIV_N;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                r = p; e.hi = r[63:32]; e.lo = r[31:0];
            end
            3'd1: begin
                p = longint'(a) * longint'(b);
                r = p; e.hi = r[63:32]; e.lo = r[31:0];
            end
            3'd2, 3'd3: begin
                if (b != 32'd0) begin
                    sa = (op == 3'd2) ? longint'($signed(a)) : longint'(a);
                    sb = (op == 3'd2) ? longint'($signed(b)) : longint'(b);
                    q  = sa / sb;
                    rm = sa % sb;
                    r = q;  e.lo = r[31:0];
                    r = rm; e.hi = r[31:0];
                end
            end
            default: ;
        endcase
        m_hi = e.hi;
        m_lo = e.lo;
        return e;
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_en = 1'b1;
        mdu_op = op;
        src_a  = a;
        src_b  = b;
        cycle();
        mdu_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            cycle();
            k++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e);
        q_done.push_back(e);
        issue(op, a, b);
        chk("busy_start", {31'd0, busy}, 32'd1);
        wait_idle(e.n + 2);
    endtask

    // Monitor: completion (busy falling) and read-data checks.
    initial begin
        bit   prev_busy = 1'b0;
        int   busy_len  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_len++;
            end else begin
                if (prev_busy) begin
                    if (abort_flag) begin
                        abort_flag = 1'b0;
                    end else if (q_done.size() == 0) begin
                        chk("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = q_done.pop_front();
                        chk("done_hi", hi_q, e.hi);
                        chk("done_lo", lo_q, e.lo);
                        chk("busy_len", 32'(busy_len), 32'(e.n));
                    end
                end
                busy_len = 0;
            end
            prev_busy = busy;

            if (mdu_en && (mdu_op == 3'd4 || mdu_op == 3'd5)) begin
                if (q_read.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    chk("mdu_out_read", mdu_out, q_read.pop_front());
                end
            end else begin
                chk("mdu_out_zero", mdu_out, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          k;

        reset  = 1'b1;
        mdu_en = 1'b0;
        mdu_op = 3'd0;
        src_a  = 32'd0;
        src_b  = 32'd0;
        #1;
        chk("rst_hi", hi_q, 32'd0);
        chk("rst_lo", lo_q, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        chk("rst_out", mdu_out, 32'd0);
        #2;
        reset = 1'b0;

        // Directed arithmetic cases (start on the first edge after reset).
        e = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_N};
        do_md(3'd0, 32'hFFFF_FFFF, 32'd2, e);
        e = '{32'h0000_0001, 32'hFFFF_FFFE, MULT_N};
        do_md(3'd1, 32'hFFFF_FFFF, 32'd2, e);
        q_read.push_back(32'h0000_0001);
        issue(3'd4, 32'd0, 32'd0);
        e = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        do_md(3'd2, 32'hFFFF_FFF9, 32'd2, e);
        e = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        do_md(3'd3, 32'd7, 32'd0, e);
        e = '{32'h0000_0000, 32'h8000_0000, DIV_N};
        do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, e);
        q_read.push_back(32'h8000_0000);
        issue(3'd5, 32'd0, 32'd0);
        m_hi = 32'h0000_0000;
        m_lo = 32'h8000_0000;

        // mthi then reads.
        issue(3'd6, 32'h1234_5678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi_q, 32'h1234_5678);
        m_hi = 32'h1234_5678;
        q_read.push_back(m_lo);
        issue(3'd5, 32'd0, 32'd0);
        q_read.push_back(32'h1234_5678);
        issue(3'd4, 32'd0, 32'd0);
        chk("mf_busy", {31'd0, busy}, 32'd0);

        // Second mult held on the bus while the first is busy.
        e = '{32'hFFFF_FFFF, 32'hFFFF_FFF4, MULT_N};
        q_done.push_back(e);
        e = '{32'h0000_0001, 32'h0000_0000, MULT_N};
        q_done.push_back(e);
        mdu_en = 1'b1; mdu_op = 3'd0; src_a = 32'd3; src_b = 32'hFFFF_FFFC;
        cycle();
        src_a = 32'h0001_0000; src_b = 32'h0001_0000;
        k = 0;
        while (busy && k < MULT_N + 3) begin
            chk("held_stall", {31'd0, md_stall}, 32'd1);
            chk("held_hi_keep", hi_q, 32'h1234_5678);
            cycle();
            k++;
        end
        chk("held_idle", {31'd0, busy}, 32'd0);
        chk("held_stall_idle", {31'd0, md_stall}, 32'd1);
        cycle();
        chk("held_accept", {31'd0, busy}, 32'd1);
        mdu_en = 1'b0;
        wait_idle(MULT_N + 2);
        m_hi = 32'h0000_0001;
        m_lo = 32'h0000_0000;

        // Reset in the middle of a mult.
        issue(3'd0, 32'd5, 32'd7);
        cycle();
        cycle();
        abort_flag = 1'b1;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi_q, 32'd0);
        chk("abort_lo", lo_q, 32'd0);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (8) cycle();
        chk("abort_late_hi", hi_q, 32'd0);
        chk("abort_late_lo", lo_q, 32'd0);
        chk("abort_late_busy", {31'd0, busy}, 32'd0);

        // Start on the first edge after a reset release.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        e = model_md(3'd0, 32'd6, 32'd7);
        do_md(3'd0, 32'd6, 32'd7, e);

        // Randomized back-to-back traffic against the model.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rnd();
            b  = rnd();
            if (op <= 3'd3) begin
                e = model_md(op, a, b);
                do_md(op, a, b, e);
            end else if (op == 3'd4) begin
                q_read.push_back(m_hi);
                issue(op, a, b);
            end else if (op == 3'd5) begin
                q_read.push_back(m_lo);
                issue(op, a, b);
            end else if (op == 3'd6) begin
                m_hi = a;
                issue(op, a, b);
            end else begin
                m_lo = a;
                issue(op, a, b);
            end
        end

        cycle();
        cycle();
        chk("final_hi", hi_q, m_hi);
        chk("final_lo", lo_q, m_lo);
        chk("q_done_drained", 32'(q_done.size()), 32'd0);
        chk("q_read_drained", 32'(q_read.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_core.md
MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mdu_en  input  1  E-stage instruction is an MDU instruction (decoder aluSel=1).
REQ-006 mdu_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo.
REQ-007 src_a  input  32  rs operand, already forwarded.
REQ-008 src_b  input  32  rt operand, already forwarded.
REQ-009 mdu_out  output  32  mfhi/mflo read data; combinational.
REQ-010 busy  output  1  multi-cycle operation in progress; registered.
REQ-011 md_stall  output  1  combinational: busy | (mdu_en & mdu_op<=3); D-stage hazard unit stalls MDU instructions on it.
REQ-012 hi_q, lo_q  output  32 each  architectural HI/LO, registered.

Function
REQ-013 Start condition: mdu_en=1, mdu_op in 0..3, busy=0; sampled at the rising edge.
REQ-014 On start: latch the 64-bit result into pending registers, load the down-counter with MULT_CYCLES or DIV_CYCLES, set busy=1.
REQ-015 State machine: IDLE -> (start) RUN -> (counter==1 at edge) IDLE; the counter decrements every edge in RUN.
REQ-016 On the RUN->IDLE edge: write the pending result to HI/LO and clear busy. busy is high for exactly N cycles, and new HI/LO is visible in the first cycle busy=0.
REQ-017 mult: signed 32x32->64. multu: unsigned 32x32->64. HI = bits 63:32, LO = bits 31:0.
REQ-018 div: signed. LO = quotient truncated toward zero. HI = remainder with the sign of the dividend.
REQ-019 divu: unsigned. LO = quotient, HI = remainder.
REQ-020 Divide by zero: the op still takes DIV_CYCLES, and HI/LO are left unchanged at completion.
REQ-021 Signed div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-022 mthi/mtlo with busy=0: HI or LO = src_a at the next edge, single cycle, busy stays 0.
REQ-023 mfhi/mflo: mdu_out = hi_q or lo_q combinationally. mdu_out = 0 for all other ops or when mdu_en=0.
REQ-024 mdu_en with any op while busy=1: ignored and no state change. Upstream guarantees this never happens via md_stall.
REQ-025 Back-to-back: a start in the first cycle after completion is accepted, and its operands see the updated HI/LO.

Reset
REQ-026 reset=1 forces immediately and asynchronously: HI=0, LO=0, pending=0, counter=0, state IDLE, busy=0.
REQ-027 Reset mid-operation aborts the operation and discards the pending result. HI/LO read 0 after reset release.
REQ-028 The first edge after reset deassertion can accept a start.

Structure
REQ-029 Shared package mdu_pkg holds: mdu_op encodings 0..7 (matching the decoder's ALUOP values when aluSel=1), MULT_CYCLES/DIV_CYCLES defaults, and the state enum IDLE/RUN.
REQ-030 The design is a single module with no sub-module. The arithmetic uses behavioural */÷ on latched operands, and the counter/FSM is inline.

Verification
REQ-031 mult src_a=0xFFFFFFFF, src_b=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. With multu on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 div src_a=-7 (0xFFFFFFF9), src_b=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. With divu 7/0 -> HI/LO unchanged after 10 cycles.
REQ-033 mthi 0x12345678, then mflo/mfhi -> hi_q=0x12345678 next cycle, mdu_out=0x12345678 on mfhi, busy never asserted.
REQ-034 mult started, then reset pulsed at cycle 3 -> busy=0, HI=LO=0 at once, and no later write.
REQ-035 mult issued with mdu_en held and a second mult presented while busy -> md_stall=1 throughout. The second op is ignored until busy=0, then accepted the following cycle.
